mem_copy_sequencer: RTL and testbench

//  Parametrised ROM/RAM-to-RAM block-copy controller. Latches src base, dst base and length on a start

---
 rtl/mem_copy_sequencer_pkg.sv | 22 ++
 rtl/mem_copy_sequencer_if.sv | 38 +++
 rtl/mem_copy_sequencer_valid_pipe.sv | 36 +++
 rtl/mem_copy_sequencer.sv | 151 +++++++++++++++
 tb/tb_mem_copy_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_copy_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_copy_pkg
// Purpose : Shared types and limits for the block-copy sequencer.
// Revision: 1.0  initial release
// ============================================================================
package mem_copy_pkg;

    // Copy controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Supported source read latency range.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/mem_copy_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_copy_sequencer_if
// Purpose : Command, status and memory-port bundle of the copy sequencer.
//           slave  = sequencer side, master = controller/memory side.
// Revision: 1.0  initial release
// ============================================================================
interface mem_copy_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start_sig;
    logic              abort_sig;
    logic              rev_mode;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W:0]   length;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              write_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done_sig;
    logic              aborted;

    modport slave (
        input  start_sig, abort_sig, rev_mode, src_base, dst_base, length, rd_data,
        output rd_en, rd_addr, write_en, wr_addr, wr_data, busy, done_sig, aborted
    );

    modport master (
        output start_sig, abort_sig, rev_mode, src_base, dst_base, length, rd_data,
        input  rd_en, rd_addr, write_en, wr_addr, wr_data, busy, done_sig, aborted
    );
endinterface
`default_nettype wire

// File: rtl/mem_copy_sequencer_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module  : copy_valid_pipe
// Purpose : RD_LAT-deep shift register tracking which cycles carry returned
//           read data; the last stage marks a word to be written.
// Revision: 1.0  initial release
// ============================================================================
module copy_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_tap,
    output logic o_any_valid
);
    logic [RD_LAT-1:0] r_stages;

    // Shift read tags toward the write tap; flush discards in-flight words.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_stages <= '0;
        end else begin
            r_stages[0] <= i_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_tap       = r_stages[RD_LAT-1];
    assign o_any_valid = |r_stages;

endmodule
`default_nettype wire

// File: rtl/mem_copy_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mem_copy_sequencer
// Purpose : Block copy from a synchronous read memory to a write port, one
//           read per cycle, forward or reversed destination, with abort.
// Revision: 1.0  initial release
// ============================================================================
module mem_copy_sequencer
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_copy_sequencer_if.slave bus
);
    localparam logic [ADDR_W:0]   c_max_len  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_one_len  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_one_addr = {{(ADDR_W-1){1'b0}}, 1'b1};

    generate
        if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_rd_lat_invalid
            $error("mem_copy_sequencer: RD_LAT must be within 1..4");
        end
    endgenerate

    state_t            r_state;
    logic              r_rev;
    logic              r_abort_seen;
    logic [ADDR_W:0]   r_rd_left;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_write_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    logic              w_flush;
    logic              w_tap;
    logic              w_any_valid;
    logic              w_wr_fire;
    logic [ADDR_W:0]   w_len;

    // Lengths beyond the memory depth copy the whole memory once.
    assign w_len     = (bus.length > c_max_len) ? c_max_len : bus.length;
    assign w_flush   = bus.abort_sig && ((r_state == ISSUE) || (r_state == DRAIN));
    assign w_wr_fire = w_tap && !w_flush;

    copy_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_valid_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (w_flush),
        .i_valid     (r_rd_en),
        .o_tap       (w_tap),
        .o_any_valid (w_any_valid)
    );

    // Copy FSM, read/write address counters and all registered outputs.
    // A zero-length or aborted copy goes through DRAIN with an empty pipe,
    // which then finishes in one cycle so done_sig lands one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rev        <= 1'b0;
            r_abort_seen <= 1'b0;
            r_rd_left    <= '0;
            r_wr_ptr     <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_write_en   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_write_en <= w_wr_fire;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            if (w_wr_fire) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= bus.rd_data;
                r_wr_ptr  <= r_rev ? (r_wr_ptr - c_one_addr) : (r_wr_ptr + c_one_addr);
            end
            case (r_state)
                IDLE: begin
                    if (bus.start_sig && !bus.abort_sig) begin
                        r_busy       <= 1'b1;
                        r_rev        <= bus.rev_mode;
                        r_wr_ptr     <= bus.dst_base;
                        r_rd_addr    <= bus.src_base;
                        r_abort_seen <= 1'b0;
                        if (w_len == '0) begin
                            r_state <= DRAIN;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_rd_left <= w_len - c_one_len;
                            r_state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.abort_sig) begin
                        r_rd_en      <= 1'b0;
                        r_rd_left    <= '0;
                        r_abort_seen <= 1'b1;
                        r_state      <= DRAIN;
                    end else if (r_rd_left != '0) begin
                        r_rd_addr <= r_rd_addr + c_one_addr;
                        r_rd_left <= r_rd_left - c_one_len;
                    end else begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.abort_sig) begin
                        r_abort_seen <= 1'b1;
                    end else if (!w_any_valid) begin
                        r_done    <= 1'b1;
                        r_aborted <= r_abort_seen;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en    = r_rd_en;
    assign bus.rd_addr  = r_rd_addr;
    assign bus.write_en = r_write_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.done_sig = r_done;
    assign bus.aborted  = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_copy_sequencer
// Purpose : Directed self-checking bench; three sequencers with read
//           latency 1, 2 and 3 share one clock and reset.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_copy_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   sel     = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_copy_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();
    mem_copy_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus2 ();
    mem_copy_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus3 ();

    mem_copy_sequencer #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) u_dut_lat1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_copy_sequencer #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) u_dut_lat2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mem_copy_sequencer #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) u_dut_lat3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic [7:0] rom_val(input logic [3:0] a);
        return 8'((int'(a) * 37) + 11);
    endfunction

    // Source memories with read latency 1, 2 and 3.
    logic [7:0] r_m1;
    logic [7:0] r_m2 [2];
    logic [7:0] r_m3 [3];
    always @(posedge clk) begin
        r_m1    <= rom_val(bus1.rd_addr);
        r_m2[0] <= rom_val(bus2.rd_addr);
        r_m2[1] <= r_m2[0];
        r_m3[0] <= rom_val(bus3.rd_addr);
        r_m3[1] <= r_m3[0];
        r_m3[2] <= r_m3[1];
    end
    assign bus1.rd_data = r_m1;
    assign bus2.rd_data = r_m2[1];
    assign bus3.rd_data = r_m3[2];

    // Outputs of the instance under test.
    logic       w_rd_en, w_write_en, w_busy, w_done, w_aborted;
    logic [3:0] w_rd_addr, w_wr_addr;
    logic [7:0] w_wr_data;
    always_comb begin
        w_rd_en = bus3.rd_en; w_rd_addr = bus3.rd_addr; w_write_en = bus3.write_en;
        w_wr_addr = bus3.wr_addr; w_wr_data = bus3.wr_data; w_busy = bus3.busy;
        w_done = bus3.done_sig; w_aborted = bus3.aborted;
        case (sel)
            1: begin
                w_rd_en = bus1.rd_en; w_rd_addr = bus1.rd_addr; w_write_en = bus1.write_en;
                w_wr_addr = bus1.wr_addr; w_wr_data = bus1.wr_data; w_busy = bus1.busy;
                w_done = bus1.done_sig; w_aborted = bus1.aborted;
            end
            2: begin
                w_rd_en = bus2.rd_en; w_rd_addr = bus2.rd_addr; w_write_en = bus2.write_en;
                w_wr_addr = bus2.wr_addr; w_wr_data = bus2.wr_data; w_busy = bus2.busy;
                w_done = bus2.done_sig; w_aborted = bus2.aborted;
            end
            default: ;
        endcase
    end

    typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } ev_t;
    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t done_q[$];
    int  busy_q[$];

    function automatic ev_t mk_ev(input int c, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.cyc = c; e.addr = a; e.data = d;
        return e;
    endfunction

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (w_rd_en)    rd_q.push_back(mk_ev(cyc, w_rd_addr, 8'h00));
        if (w_write_en) wr_q.push_back(mk_ev(cyc, w_wr_addr, w_wr_data));
        if (w_done)     done_q.push_back(mk_ev(cyc, 4'h0, {7'b0, w_aborted}));
        if (w_busy)     busy_q.push_back(cyc);
    end

    task automatic clear_logs();
        rd_q.delete(); wr_q.delete(); done_q.delete(); busy_q.delete();
    endtask

    task automatic set_inputs(input int which, input logic st, input logic ab, input logic rv,
                              input logic [3:0] s, input logic [3:0] d, input logic [4:0] len);
        case (which)
            1: begin bus1.start_sig = st; bus1.abort_sig = ab; bus1.rev_mode = rv;
                     bus1.src_base = s; bus1.dst_base = d; bus1.length = len; end
            2: begin bus2.start_sig = st; bus2.abort_sig = ab; bus2.rev_mode = rv;
                     bus2.src_base = s; bus2.dst_base = d; bus2.length = len; end
            default: begin bus3.start_sig = st; bus3.abort_sig = ab; bus3.rev_mode = rv;
                     bus3.src_base = s; bus3.dst_base = d; bus3.length = len; end
        endcase
    endtask

    // Pulses start for one cycle (t0 = cycle 0), then scrambles the data inputs.
    task automatic start_copy(input int which, input logic [3:0] s, input logic [3:0] d,
                              input logic [4:0] len, input logic rv, output int t0);
        @(negedge clk);
        sel = which;
        clear_logs();
        set_inputs(which, 1'b1, 1'b0, rv, s, d, len);
        t0 = cyc;
        @(negedge clk);
        set_inputs(which, 1'b0, 1'b0, ~rv, ~s, ~d, 5'd1);
    endtask

    function automatic int first_done(input int t0);
        return (done_q.size() > 0) ? done_q[0].cyc - t0 : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus1.rd_en, bus1.write_en, bus1.busy, bus1.done_sig, bus1.aborted, bus1.rd_addr, bus1.wr_addr, bus1.wr_data} !== 27'd0)
            $display("FAIL reset_outputs_lat1: rd_en=%0b we=%0b busy=%0b done=%0b, want all 0", bus1.rd_en, bus1.write_en, bus1.busy, bus1.done_sig); else n_pass++;
        n_total++;
        if ({bus2.rd_en, bus2.write_en, bus2.busy, bus2.done_sig, bus2.aborted} !== 5'd0)
            $display("FAIL reset_outputs_lat2: got %b want 00000", {bus2.rd_en, bus2.write_en, bus2.busy, bus2.done_sig, bus2.aborted}); else n_pass++;
        n_total++;
        if ({bus3.rd_en, bus3.write_en, bus3.busy, bus3.done_sig, bus3.aborted} !== 5'd0)
            $display("FAIL reset_outputs_lat3: got %b want 00000", {bus3.rd_en, bus3.write_en, bus3.busy, bus3.done_sig, bus3.aborted}); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        int t0, bad;
        start_copy(1, 4'd0, 4'd0, 5'd16, 1'b0, t0);
        repeat (30) @(negedge clk);
        n_total++;
        if (rd_q.size() !== 16) $display("FAIL fwd_rd_count: got %0d want 16", rd_q.size()); else n_pass++;
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i].cyc - t0 !== i + 1 || rd_q[i].addr !== 4'(i)) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL fwd_rd_seq: got %0d bad reads want 0", bad); else n_pass++;
        n_total++;
        if (wr_q.size() !== 16) $display("FAIL fwd_wr_count: got %0d want 16", wr_q.size()); else n_pass++;
        bad = 0;
        foreach (wr_q[i])
            if (wr_q[i].cyc - t0 !== i + 3 || wr_q[i].addr !== 4'(i) || wr_q[i].data !== rom_val(4'(i))) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL fwd_wr_seq: got %0d bad writes want 0", bad); else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || first_done(t0) !== 19)
            $display("FAIL fwd_done: got count %0d cycle %0d want 1 at 19", done_q.size(), first_done(t0)); else n_pass++;
        n_total++;
        if (busy_q.size() !== 19 || busy_q[0] - t0 !== 1 || busy_q[busy_q.size()-1] - t0 !== 19)
            $display("FAIL fwd_busy: got %0d busy cycles want 19 (cycles 1..19)", busy_q.size()); else n_pass++;
    endtask

    task automatic test_reverse_wrap();
        int t0, bad;
        logic [3:0] exp_ra [4];
        logic [3:0] exp_wa [4];
        exp_ra = '{4'd14, 4'd15, 4'd0, 4'd1};
        exp_wa = '{4'd2, 4'd1, 4'd0, 4'd15};
        start_copy(3, 4'd14, 4'd2, 5'd4, 1'b1, t0);
        repeat (20) @(negedge clk);
        n_total++;
        if (rd_q.size() !== 4) $display("FAIL rev_rd_count: got %0d want 4", rd_q.size()); else n_pass++;
        bad = 0;
        foreach (rd_q[i]) if (i < 4 && (rd_q[i].cyc - t0 !== i + 1 || rd_q[i].addr !== exp_ra[i])) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL rev_rd_seq: got %0d bad reads want 0", bad); else n_pass++;
        n_total++;
        if (wr_q.size() !== 4) $display("FAIL rev_wr_count: got %0d want 4", wr_q.size()); else n_pass++;
        bad = 0;
        foreach (wr_q[i])
            if (i < 4 && (wr_q[i].cyc - t0 !== i + 5 || wr_q[i].addr !== exp_wa[i] || wr_q[i].data !== rom_val(exp_ra[i]))) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL rev_wr_seq: got %0d bad writes want 0", bad); else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || first_done(t0) !== 9)
            $display("FAIL rev_done: got count %0d cycle %0d want 1 at 9", done_q.size(), first_done(t0)); else n_pass++;
    endtask

    task automatic test_len_zero();
        int t0;
        start_copy(1, 4'd3, 4'd5, 5'd0, 1'b0, t0);
        repeat (10) @(negedge clk);
        n_total++;
        if (rd_q.size() + wr_q.size() !== 0)
            $display("FAIL len0_no_access: got %0d reads %0d writes want 0", rd_q.size(), wr_q.size()); else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || first_done(t0) !== 2 || done_q[0].data !== 8'd0)
            $display("FAIL len0_done: got count %0d cycle %0d want 1 at 2 not aborted", done_q.size(), first_done(t0)); else n_pass++;
        n_total++;
        if (busy_q.size() !== 2) $display("FAIL len0_busy: got %0d busy cycles want 2", busy_q.size()); else n_pass++;
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        sel = 1;
        clear_logs();
        set_inputs(1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd4);
        @(negedge clk);
        set_inputs(1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 5'd4);
        @(negedge clk);
        set_inputs(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd4);
        repeat (6) @(negedge clk);
        n_total++;
        if (busy_q.size() + rd_q.size() + done_q.size() !== 0)
            $display("FAIL start_with_abort: got busy %0d reads %0d dones %0d want 0", busy_q.size(), rd_q.size(), done_q.size()); else n_pass++;
    endtask

    task automatic test_abort();
        int t0, bad;
        start_copy(2, 4'd3, 4'd8, 5'd16, 1'b0, t0);
        repeat (5) @(negedge clk);
        set_inputs(2, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 5'd16);
        @(negedge clk);
        set_inputs(2, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 5'd16);
        repeat (20) @(negedge clk);
        n_total++;
        if (rd_q.size() !== 6 || rd_q[rd_q.size()-1].cyc - t0 !== 6)
            $display("FAIL abort_reads: got %0d reads want 6 ending cycle 6", rd_q.size()); else n_pass++;
        n_total++;
        if (wr_q.size() !== 3) $display("FAIL abort_wr_count: got %0d want 3", wr_q.size()); else n_pass++;
        bad = 0;
        foreach (wr_q[i])
            if (wr_q[i].cyc - t0 !== i + 4 || wr_q[i].addr !== 4'(8 + i) || wr_q[i].data !== rom_val(4'(3 + i))) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL abort_wr_seq: got %0d bad writes want 0", bad); else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || first_done(t0) !== 8 || done_q[0].data !== 8'd1)
            $display("FAIL abort_done: got count %0d cycle %0d want 1 at 8 with aborted", done_q.size(), first_done(t0)); else n_pass++;
        n_total++;
        if (busy_q.size() !== 8) $display("FAIL abort_busy: got %0d busy cycles want 8", busy_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t0, t1, bad;
        start_copy(1, 4'd5, 4'd1, 5'd8, 1'b0, t0);
        repeat (2) @(negedge clk);
        set_inputs(1, 1'b1, 1'b0, 1'b1, 4'd12, 4'd12, 5'd2);
        @(negedge clk);
        set_inputs(1, 1'b0, 1'b0, 1'b1, 4'd12, 4'd12, 5'd2);
        repeat (6) @(negedge clk);
        set_inputs(1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 5'd3);
        @(negedge clk);
        set_inputs(1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 5'd3);
        @(negedge clk);
        set_inputs(1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd0, 5'd2);
        t1 = cyc;
        @(negedge clk);
        set_inputs(1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 5'd9);
        repeat (20) @(negedge clk);
        n_total++;
        if (t1 - t0 !== 12) $display("FAIL b2b_restart_cycle: got %0d want 12", t1 - t0); else n_pass++;
        n_total++;
        if (done_q.size() !== 2 || first_done(t0) !== 11 || done_q[1].cyc - t1 !== 5)
            $display("FAIL b2b_done: got count %0d first %0d want 2 at 11 and restart+5", done_q.size(), first_done(t0)); else n_pass++;
        n_total++;
        if (wr_q.size() !== 10 || rd_q.size() !== 10)
            $display("FAIL b2b_counts: got %0d writes %0d reads want 10 and 10", wr_q.size(), rd_q.size()); else n_pass++;
        bad = 0;
        foreach (wr_q[i])
            if (i < 8 && (wr_q[i].cyc - t0 !== i + 3 || wr_q[i].addr !== 4'(1 + i) || wr_q[i].data !== rom_val(4'(5 + i)))) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL b2b_first_copy: got %0d bad writes want 0", bad); else n_pass++;
        n_total++;
        if (wr_q.size() < 10 || wr_q[8].addr !== 4'd0 || wr_q[9].addr !== 4'd15 || wr_q[9].data !== rom_val(4'd10) || wr_q[9].cyc - t1 !== 4)
            $display("FAIL b2b_second_copy: got %0d writes want rev writes at 0,15 ending restart+4", wr_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0, late;
        start_copy(1, 4'd9, 4'd3, 5'd16, 1'b0, t0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus1.rd_en, bus1.write_en, bus1.busy, bus1.done_sig, bus1.aborted, bus1.rd_addr, bus1.wr_addr, bus1.wr_data} !== 27'd0)
            $display("FAIL midreset_outputs: rd_en=%0b rd_addr=%0d we=%0b wr_data=%0d busy=%0b want all 0",
                     bus1.rd_en, bus1.rd_addr, bus1.write_en, bus1.wr_data, bus1.busy); else n_pass++;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        late = 0;
        foreach (rd_q[i]) if (rd_q[i].cyc - t0 >= 6) late++;
        foreach (wr_q[i]) if (wr_q[i].cyc - t0 >= 6) late++;
        foreach (busy_q[i]) if (busy_q[i] - t0 >= 6) late++;
        n_total++;
        if (rd_q.size() !== 5) $display("FAIL midreset_reads_before: got %0d want 5", rd_q.size()); else n_pass++;
        n_total++;
        if (late !== 0 || done_q.size() !== 0)
            $display("FAIL midreset_quiet: got %0d late events %0d dones want 0", late, done_q.size()); else n_pass++;
    endtask

    task automatic test_clamp();
        int t0, bad;
        start_copy(1, 4'd7, 4'd4, 5'd31, 1'b0, t0);
        repeat (30) @(negedge clk);
        n_total++;
        if (rd_q.size() !== 16 || wr_q.size() !== 16)
            $display("FAIL clamp_counts: got %0d reads %0d writes want 16 and 16", rd_q.size(), wr_q.size()); else n_pass++;
        bad = 0;
        foreach (wr_q[i])
            if (wr_q[i].cyc - t0 !== i + 3 || wr_q[i].addr !== 4'(4 + i) || wr_q[i].data !== rom_val(4'(7 + i))) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL clamp_wr_seq: got %0d bad writes want 0", bad); else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || first_done(t0) !== 19)
            $display("FAIL clamp_done: got count %0d cycle %0d want 1 at 19", done_q.size(), first_done(t0)); else n_pass++;
    endtask

    initial begin
        set_inputs(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0);
        set_inputs(2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0);
        set_inputs(3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0);
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_len_zero();
        test_start_abort();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_clamp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
